// File: rtl/alu_issue_pkg.sv
// Shared constants, instruction layout and opcodes for the ALU operand-issue stage.
package alu_issue_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NREG    = 8;
  localparam int unsigned ADDR_W  = $clog2(NREG);
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned RSVD_W  = 3;

  // Instruction field bit positions (lsb of each field)
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_LSB = 3;

  typedef struct packed {
    logic [SEL_W-1:0]  op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [RSVD_W-1:0] rsvd;
  } instr_t;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1
  } op_e;

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file: NREG x DATA_W, two async read ports, two write ports (port0 wins on collision).
module alu_issue_regfile
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] regs [NREG];

  // Storage update; port0 is written last so it overrides port1 at the same index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      if (we1) regs[waddr1] <= wdata1;
      if (we0) regs[waddr0] <= wdata0;
    end
  end

  assign rdata0 = regs[raddr0];
  assign rdata1 = regs[raddr1];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage feeding a combinational ALU, with writeback and one-entry bypass.
// Optional macro ALU_ISSUE_PERF_EN adds perf_issued / perf_bypass counters.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]  cfg_wdata,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [SEL_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_carry,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic [ADDR_W-1:0]  res_rd,
  output logic               res_carry,
  output logic               carry_flag
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]        perf_issued,
  output logic [31:0]        perf_bypass
`endif
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e            state;
  instr_t            instr;
  logic              retire;
  logic              accept;
  logic              byp_a;
  logic              byp_b;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              unused_rsvd;

  assign instr       = instr_t'(in_instr);
  assign unused_rsvd = ^instr.rsvd;

  // Handshake and operand selection; a retiring result overrides the stale register value
  always_comb begin
    res_valid = (state == S_FULL);
    in_ready  = (state == S_EMPTY) | res_ready;
    retire    = res_valid & res_ready;
    accept    = in_valid & in_ready;
    byp_a     = retire & (instr.rs1 == res_rd);
    byp_b     = retire & (instr.rs2 == res_rd);
    op_a      = byp_a ? alu_out : rf_a;
    op_b      = byp_b ? alu_out : rf_b;
    res_data  = alu_out;
    res_carry = alu_carry;
  end

  alu_issue_regfile u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we0    (retire),
    .waddr0 (res_rd),
    .wdata0 (alu_out),
    .we1    (cfg_we),
    .waddr1 (cfg_addr),
    .wdata1 (cfg_wdata),
    .raddr0 (instr.rs1),
    .rdata0 (rf_a),
    .raddr1 (instr.rs2),
    .rdata1 (rf_b)
  );

  // S1 state, ALU operand registers and sticky carry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      res_rd     <= '0;
      carry_flag <= 1'b0;
    end else begin
      if (retire) carry_flag <= alu_carry;
      if (accept) begin
        state   <= S_FULL;
        alu_a   <= op_a;
        alu_b   <= op_b;
        alu_sel <= instr.op;
        res_rd  <= instr.rd;
      end else if (retire) begin
        state <= S_EMPTY;
      end
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // Issue and bypass-use counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_bypass <= '0;
    end else if (accept) begin
      perf_issued <= perf_issued + 32'(1);
      if (byp_a | byp_b) perf_bypass <= perf_bypass + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic
// checked against an architectural model (register array + one pending result).
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_o;
  logic        alu_c;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic        res_carry;
  logic        carry_flag;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_bypass;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, result}
  function automatic logic [16:0] alu_fn(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      4'h0:    alu_fn = {1'b0, a} + {1'b0, b};
      4'h1:    alu_fn = {1'b0, a} - {1'b0, b};
      4'h2:    alu_fn = {1'b0, a & b};
      default: alu_fn = {1'b0, a | b};
    endcase
  endfunction

  assign {alu_c, alu_o} = alu_fn(alu_sel, alu_a, alu_b);

  alu_issue_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_o),
    .alu_carry  (alu_c),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_rd     (res_rd),
    .res_carry  (res_carry),
    .carry_flag (carry_flag)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_bypass(perf_bypass)
`endif
  );

  // Architectural model
  logic [15:0] m_rf [8];
  logic        m_cf;
  logic        p_v;
  logic [3:0]  p_op;
  logic [2:0]  p_rd;
  logic [15:0] p_a, p_b;
  logic [31:0] m_issued, m_bypass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_cf = 1'b0; p_v = 1'b0; p_op = '0; p_rd = '0; p_a = '0; p_b = '0;
    m_issued = '0; m_bypass = '0;
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    mk = {op, rd, rs1, rs2, 3'b000};
  endfunction

  // One clock cycle: drive at negedge, check against model, advance model across posedge
  task automatic step(input logic rst, input logic vld, input logic [15:0] ins, input logic rr,
                      input logic cwe, input logic [2:0] caddr, input logic [15:0] cdata);
    logic        exp_ready, ret, acc, ba, bb;
    logic [16:0] res;
    logic [2:0]  rs1, rs2;
    @(negedge clk);
    rst_n = rst; in_valid = vld; in_instr = ins; res_ready = rr;
    cfg_we = cwe; cfg_addr = caddr; cfg_wdata = cdata;
    #1;
    exp_ready = !p_v || rr;
    ret = p_v && rr;
    acc = vld && exp_ready;
    res = alu_fn(p_op, p_a, p_b);
    check("res_valid", 32'(res_valid), 32'(p_v));
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("carry_flag", 32'(carry_flag), 32'(m_cf));
    if (p_v) begin
      check("alu_a", 32'(alu_a), 32'(p_a));
      check("alu_b", 32'(alu_b), 32'(p_b));
      check("alu_sel", 32'(alu_sel), 32'(p_op));
      check("res_rd", 32'(res_rd), 32'(p_rd));
      check("res_data", 32'(res_data), 32'(res[15:0]));
      check("res_carry", 32'(res_carry), 32'(res[16]));
    end
`ifdef ALU_ISSUE_PERF_EN
    check("perf_issued", perf_issued, m_issued);
    check("perf_bypass", perf_bypass, m_bypass);
`endif
    if (!rst) begin
      model_reset();
    end else begin
      rs1 = ins[8:6];
      rs2 = ins[5:3];
      ba = ret && (p_rd == rs1);
      bb = ret && (p_rd == rs2);
      if (acc) begin
        // Operands see a result retiring this cycle, but not a same-cycle cfg write
        p_a = ba ? res[15:0] : m_rf[rs1];
        p_b = bb ? res[15:0] : m_rf[rs2];
        m_issued = m_issued + 1;
        if (ba || bb) m_bypass = m_bypass + 1;
      end
      if (cwe) m_rf[caddr] = cdata;
      if (ret) begin
        m_rf[p_rd] = res[15:0];
        m_cf = res[16];
      end
      if (acc) begin
        p_v = 1'b1; p_op = ins[15:12]; p_rd = ins[11:9];
      end else if (ret) begin
        p_v = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic rr);
    step(1'b1, 1'b0, 16'h0, rr, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic cfg(input logic [2:0] a, input logic [15:0] d);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, a, d);
  endtask

  task automatic issue(input logic [15:0] ins, input logic rr);
    step(1'b1, 1'b1, ins, rr, 1'b0, 3'd0, 16'h0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_sel", 32'(alu_sel), 32'h0);
    check("rst_res_rd", 32'(res_rd), 32'h0);

    // Load and simple add
    cfg(3'd1, 16'h00FA);
    cfg(3'd2, 16'h0002);
    issue(mk(4'h0, 3'd3, 3'd1, 3'd2), 1'b1);
    #2;
    check("load_alu_a", 32'(alu_a), 32'h00FA);
    check("load_alu_b", 32'(alu_b), 32'h0002);
    check("load_res_data", 32'(res_data), 32'h00FC);

    // Back-to-back dependency through the bypass
    issue(mk(4'h1, 3'd4, 3'd3, 3'd2), 1'b1);
    #2;
    check("b2b_alu_a", 32'(alu_a), 32'h00FC);
    check("b2b_res_data", 32'(res_data), 32'h00FA);

    // Stall for three cycles with a waiting instruction
    for (int i = 0; i < 3; i++) begin
      issue(mk(4'h0, 3'd0, 3'd4, 3'd4), 1'b0);
      #2;
      check("stall_alu_a", 32'(alu_a), 32'h00FC);
      check("stall_res_rd", 32'(res_rd), 32'd4);
    end
    issue(mk(4'h0, 3'd0, 3'd4, 3'd4), 1'b1);
    #2;
    check("stall_retire_byp", 32'(alu_a), 32'h00FA);
    idle(1'b1);

    // Carry generation
    cfg(3'd5, 16'hFFFF);
    cfg(3'd6, 16'h0001);
    issue(mk(4'h0, 3'd7, 3'd5, 3'd6), 1'b1);
    #2;
    check("carry_res_data", 32'(res_data), 32'h0000);
    check("carry_res_carry", 32'(res_carry), 32'h1);
    idle(1'b1);
    #2;
    check("carry_flag_set", 32'(carry_flag), 32'h1);

    // Writeback beats cfg write to the same register
    issue(mk(4'h0, 3'd3, 3'd1, 3'd2), 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 3'd3, 16'h1234);
    issue(mk(4'h0, 3'd0, 3'd3, 3'd3), 1'b1);
    #2;
    check("collide_r3", 32'(alu_a), 32'h00FC);
    idle(1'b1);

    // Reset while an instruction is in flight
    issue(mk(4'h0, 3'd1, 3'd5, 3'd6), 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
    #2;
    check("midrst_res_valid", 32'(res_valid), 32'h0);
    check("midrst_carry_flag", 32'(carry_flag), 32'h0);
    issue(mk(4'h0, 3'd0, 3'd1, 3'd5), 1'b1);
    #2;
    check("midrst_r1_zero", 32'(alu_a), 32'h0);
    check("midrst_r5_zero", 32'(alu_b), 32'h0);
    idle(1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 1) == 1),
           16'($urandom),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
